// File: rtl/rv32_sched_pkg.sv
// Shared types and constants for the rv32 job scheduler: FSM states,
// response status codes, core op encoding and a width helper.
package rv32_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } sched_state_e;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_NOMMIO  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Matches the io_op encoding of the mini_rv32i core.
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } core_op_e;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rv32_rr_arbiter.sv
// Combinational round-robin pick: the first set request at or above the
// pointer, wrapping around, wins.
module rv32_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant_oh,
    output logic [IW-1:0]    grant_idx,
    output logic             grant_any
);

    // Scan all requesters starting at the pointer and keep the first hit.
    always_comb begin
        int          j;
        logic [IW-1:0] jj;
        j         = 0;
        jj        = '0;
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            jj = IW'(j);
            if (!grant_any && req[jj]) begin
                grant_any     = 1'b1;
                grant_oh[jj]  = 1'b1;
                grant_idx     = jj;
            end
        end
    end

endmodule

// File: rtl/rv32_job_sched.sv
// Shares one mini_rv32i core between several requesters: picks a job
// round-robin, loads its operands, pulses the core reset, waits for done
// (bounded by a timeout) and hands the result back with a status code.
module rv32_job_sched
    import rv32_sched_pkg::*;
#(
    parameter int  N_REQ      = 4,
    parameter int  TIMEOUT    = 2000,
    parameter int  RST_CYCLES = 4,
    localparam int IW         = id_width(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    input  logic [2*N_REQ-1:0]   req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IW-1:0]        rsp_id,
    output logic [31:0]          rsp_data,
    output logic [1:0]           rsp_err,
    output logic                 core_rst,
    output logic [31:0]          core_in_a,
    output logic [31:0]          core_in_b,
    output logic [1:0]           core_op,
    input  logic [31:0]          core_out_res,
    input  logic                 core_out_valid,
    input  logic                 core_done,
    output logic                 busy
);

    localparam int CW = $clog2(TIMEOUT + RST_CYCLES + 1) + 1;

    sched_state_e      state;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     rr_next;
    logic              armed;
    logic [N_REQ-1:0]  grant_oh;
    logic [IW-1:0]     grant_idx;
    logic              grant_any;
    logic              take;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;
    logic [1:0]        sel_op;

    rv32_rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // A grant is only offered in IDLE once the first clock after reset has passed,
    // so req_ready is guaranteed low while rst_n is asserted.
    assign take      = (state == IDLE) && armed && grant_any;
    assign req_ready = take ? grant_oh : '0;
    assign busy      = (state != IDLE);
    assign rr_next   = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Route the winning requester's operand slices to the load registers.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_a  = req_a[i*32 +: 32];
                sel_b  = req_b[i*32 +: 32];
                sel_op = req_op[i*2 +: 2];
            end
        end
    end

    // Job sequencer: grant, hold the core in reset, run with timeout, respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rr_ptr    <= '0;
            armed     <= 1'b0;
            core_rst  <= 1'b1;
            core_in_a <= '0;
            core_in_b <= '0;
            core_op   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= ERR_OK;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    core_rst <= 1'b1;
                    if (take) begin
                        core_in_a <= sel_a;
                        core_in_b <= sel_b;
                        core_op   <= sel_op;
                        rsp_id    <= grant_idx;
                        rr_ptr    <= rr_next;
                        cnt       <= '0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (cnt == CW'(RST_CYCLES - 1)) begin
                        cnt      <= '0;
                        core_rst <= 1'b0;
                        state    <= RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (core_done) begin
                        rsp_data  <= core_out_valid ? core_out_res : '0;
                        rsp_err   <= core_out_valid ? ERR_OK : ERR_NOMMIO;
                        rsp_valid <= 1'b1;
                        core_rst  <= 1'b1;
                        state     <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        rsp_data  <= '0;
                        rsp_err   <= ERR_TIMEOUT;
                        rsp_valid <= 1'b1;
                        core_rst  <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    core_rst <= 1'b1;
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_job_sched.sv
// Randomized self-checking bench for rv32_job_sched with a behavioural
// core model and a job-level reference model of arbitration and timing.
module tb_rv32_job_sched;
    import rv32_sched_pkg::*;

    localparam int NREQ    = 4;
    localparam int TMO     = 100;
    localparam int RSTC    = 4;
    localparam int IW      = 2;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic [2*NREQ-1:0]   req_op;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IW-1:0]       rsp_id;
    logic [31:0]         rsp_data;
    logic [1:0]          rsp_err;
    logic                core_rst;
    logic [31:0]         core_in_a;
    logic [31:0]         core_in_b;
    logic [1:0]          core_op;
    logic [31:0]         core_out_res;
    logic                core_out_valid;
    logic                core_done;
    logic                busy;

    int testsRun;
    int failCount;

    // Requester-side reference state
    bit          pend[NREQ];
    logic [31:0] opA[NREQ];
    logic [31:0] opB[NREQ];
    logic [1:0]  opOp[NREQ];
    int          ptrModel;

    // Core model behaviour for the current job: 0 ok, 1 no MMIO write, 2 hang
    int coreDelay;
    int coreMode;
    int relCnt;

    rv32_job_sched #(
        .N_REQ      (NREQ),
        .TIMEOUT    (TMO),
        .RST_CYCLES (RSTC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_op         (req_op),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .core_rst       (core_rst),
        .core_in_a      (core_in_a),
        .core_in_b      (core_in_b),
        .core_op        (core_op),
        .core_out_res   (core_out_res),
        .core_out_valid (core_out_valid),
        .core_done      (core_done),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] refResult(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic int refGrant();
        for (int k = 0; k < NREQ; k++) begin
            if (pend[(ptrModel + k) % NREQ]) return (ptrModel + k) % NREQ;
        end
        return -1;
    endfunction

    // Core model: counts edges since core_rst release and raises done after coreDelay edges.
    always @(posedge clk) begin
        #1;
        if (core_rst) begin
            relCnt         = 0;
            core_done      = 1'b0;
            core_out_valid = 1'b0;
            core_out_res   = '0;
        end else begin
            relCnt++;
            if (coreMode != 2 && relCnt - 1 >= coreDelay && !core_done) begin
                core_done      = 1'b1;
                core_out_valid = (coreMode == 0);
                core_out_res   = (coreMode == 0) ? refResult(core_in_a, core_in_b, core_op)
                                                 : (32'hDEAD_BEEF ^ $urandom);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]        = pend[i];
            req_a[i*32 +: 32]   = opA[i];
            req_b[i*32 +: 32]   = opB[i];
            req_op[i*2 +: 2]    = opOp[i];
        end
    endtask

    task automatic step();
        @(negedge clk);
        applyStimulus();
        #1;
    endtask

    task automatic newJob(input int i);
        pend[i] = 1'b1;
        opA[i]  = $urandom;
        opB[i]  = $urandom;
        opOp[i] = 2'($urandom_range(0, 3));
    endtask

    // mode 0: nothing, 1: every idle requester, 2: random with at least one pending
    task automatic refill(input int mode);
        bit any;
        any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1))) newJob(i);
            if (pend[i]) any = 1'b1;
        end
        if (mode != 0 && !any) newJob(int'($urandom_range(0, NREQ - 1)));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ctrl"},
                    64'({core_rst, busy, rsp_valid, req_ready, core_op, rsp_id, rsp_err}),
                    64'({1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 2'b00, 2'b00}));
        checkOutput({tag, "_in_a"}, 64'(core_in_a), 64'(0));
        checkOutput({tag, "_in_b"}, 64'(core_in_b), 64'(0));
        checkOutput({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
    endtask

    task automatic resetAbort();
        rst_n = 1'b0;
        #1;
        checkResetValues("abort_rst");
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        newJob(2);
        newJob(3);
        ptrModel = 0;
        applyStimulus();
        repeat (3) begin
            step();
            checkOutput("abort_hold", 64'({req_ready, core_rst, busy}), 64'({4'b0000, 1'b1, 1'b0}));
        end
        rst_n = 1'b1;
    endtask

    task automatic runJob(input int delay, input int mode, input int hold,
                          input bit expectImmediate, input int refillMode, input int abortAt);
        int          waitCnt, n, rstHigh, g, m;
        bit          sawLow, sawReady;
        logic [31:0] ga, gb, expData;
        logic [1:0]  gop, expErr;
        waitCnt = 0;
        while (req_ready == '0 && waitCnt < 20) begin
            step();
            waitCnt++;
        end
        if (req_ready == '0) begin
            checkOutput("grant_wait", 64'(waitCnt), 64'(0));
            return;
        end
        if (expectImmediate) checkOutput("grant_latency", 64'(waitCnt), 64'(0));
        g = refGrant();
        if (g < 0) begin
            checkOutput("grant_unexpected", 64'(req_ready), 64'(0));
            return;
        end
        checkOutput("req_ready_grant", 64'(req_ready), 64'(1) << g);
        checkOutput("idle_state", 64'({busy, core_rst, rsp_valid}), 64'({1'b0, 1'b1, 1'b0}));
        ga  = opA[g];
        gb  = opB[g];
        gop = opOp[g];
        pend[g]   = 1'b0;
        ptrModel  = (g + 1) % NREQ;
        coreDelay = delay;
        coreMode  = mode;

        n = 0; rstHigh = 0; sawLow = 1'b0; sawReady = 1'b0;
        do begin
            step();
            n++;
            if (abortAt > 0 && n == abortAt) begin
                resetAbort();
                return;
            end
            if (req_ready != '0) sawReady = 1'b1;
            if (!sawLow && core_rst) rstHigh++;
            else sawLow = 1'b1;
            if (n == RSTC + 1) begin
                checkOutput("core_in_a", 64'(core_in_a), 64'(ga));
                checkOutput("core_in_b", 64'(core_in_b), 64'(gb));
                checkOutput("core_op", 64'(core_op), 64'(gop));
                checkOutput("core_rst_run", 64'(core_rst), 64'(0));
            end
        end while (!rsp_valid && n < RSTC + TMO + 20);

        m = (mode == 2 || delay + 1 > TMO) ? TMO : delay + 1;
        if (mode != 2 && delay + 1 <= TMO) begin
            expData = (mode == 0) ? refResult(ga, gb, gop) : 32'h0;
            expErr  = (mode == 0) ? ERR_OK : ERR_NOMMIO;
        end else begin
            expData = 32'h0;
            expErr  = ERR_TIMEOUT;
        end
        checkOutput("ready_pulse", 64'(sawReady), 64'(0));
        checkOutput("rst_cycles", 64'(rstHigh), 64'(RSTC));
        checkOutput("latency", 64'(n), 64'(1 + RSTC + m));
        if (!rsp_valid) return;
        checkOutput("rsp_id", 64'(rsp_id), 64'(g));
        checkOutput("rsp_data", 64'(rsp_data), 64'(expData));
        checkOutput("rsp_err", 64'(rsp_err), 64'(expErr));
        checkOutput("resp_park", 64'({core_rst, busy}), 64'({1'b1, 1'b1}));

        refill(refillMode);
        for (int h = 0; h < hold; h++) begin
            step();
            checkOutput("hold_stable",
                        64'({rsp_valid, rsp_id, rsp_err, rsp_data, busy, req_ready}),
                        64'({1'b1, 2'(g), expErr, expData, 1'b1, 4'b0000}));
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checkOutput("rsp_released", 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, failed %0d", failCount);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int d, r, md;
        testsRun  = 0;
        failCount = 0;
        ptrModel  = 0;
        coreDelay = 1;
        coreMode  = 2;
        relCnt    = 0;
        core_done      = 1'b0;
        core_out_valid = 1'b0;
        core_out_res   = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; opA[i] = '0; opB[i] = '0; opOp[i] = '0;
        end
        applyStimulus();
        repeat (3) step();
        checkResetValues("por");

        // Single job on requester 0: 21 + 9
        pend[0] = 1'b1; opA[0] = 32'd21; opB[0] = 32'd9; opOp[0] = OP_ADD;
        applyStimulus();
        rst_n = 1'b1;
        runJob(50, 0, 0, 1'b0, 1, 0);

        // Round-robin with every requester kept busy
        repeat (5) runJob(10, 0, 0, 1'b1, 1, 0);

        // Timeout, done coinciding with the timeout, done one cycle too late, no MMIO write
        runJob(0, 2, 0, 1'b1, 1, 0);
        runJob(TMO - 1, 0, 0, 1'b1, 1, 0);
        runJob(TMO, 0, 0, 1'b1, 1, 0);
        runJob(5, 1, 0, 1'b1, 1, 0);

        // Backpressure with all requesters pending
        runJob(20, 0, 10, 1'b1, 1, 0);

        // Random jobs
        repeat (25) begin
            d  = int'($urandom_range(1, 110));
            r  = int'($urandom_range(0, 9));
            md = (r < 6) ? 0 : ((r < 8) ? 1 : 2);
            runJob(d, md, int'($urandom_range(0, 4)), 1'b1, 2, 0);
        end

        // Reset during RUN, then requester 2 must win from pointer 0
        runJob(200, 2, 0, 1'b1, 2, RSTC + 3);
        runJob(15, 0, 0, 1'b0, 2, 0);
        runJob(15, 0, 2, 1'b1, 2, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/rv32_job_sched.md
Name: rv32_job_sched

Overview:
Shares one mini_rv32i core between N_REQ requesters, each submitting an MMIO job (operand a, operand b, op code). Arbitrates round-robin and loads the winner's operands onto the core's io_in_a/io_in_b/io_op. Pulses the core's active-high rst, waits for done with a cycle timeout, then returns io_out_res plus a status code to the requester. Sits between host-side requesters and the core instance, replacing the fixed-operand bench sequencing.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 2000, maximum RUN cycles before a job is aborted
RST_CYCLES, 4, cycles core_rst is held high before each job

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester job pending
req_ready  out  N_REQ  one-hot accept pulse
req_a  in  32*N_REQ  operand a, slice i = requester i
req_b  in  32*N_REQ  operand b
req_op  in  2*N_REQ  op code
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_id  out  clog2(N_REQ)  requester index of response
rsp_data  out  32  captured io_out_res, or 0 on error
rsp_err  out  2  00 ok, 01 no MMIO write, 10 timeout
core_rst  out  1  drives core rst, active-high
core_in_a  out  32  drives core io_in_a
core_in_b  out  32  drives core io_in_b
core_op  out  2  drives core io_op
core_out_res  in  32  core io_out_res
core_out_valid  in  1  core io_out_valid
core_done  in  1  core done
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async on rst_n low, released synchronously): state IDLE, core_rst=1, core_in_a/b=0, core_op=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=00, busy=0, rr pointer=0, counters=0.
- Reset mid-job aborts the job with no response. The core is held in reset because core_rst=1.
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE:
  - core_rst=1.
  - If any req_valid, grant the first set bit searching from rr pointer upward with wrap. Assert req_ready[grant] for exactly that cycle.
  - Register req_a/req_b/req_op of the grant into core_in_a/core_in_b/core_op and the grant index into rsp_id. Set rr pointer = grant+1 mod N_REQ. Go to LOAD.
- LOAD: core_rst=1 for RST_CYCLES cycles, counted from LOAD entry. Then go to RUN with core_rst=0 on the first RUN cycle.
- RUN:
  - Cycle counter starts at 0 and increments each cycle. Operands are held stable.
  - core_done sampled high: capture core_out_valid ? (core_out_res, 00) : (0, 01). Go to RESP.
  - Counter reaches TIMEOUT-1 without done: capture (0, 10). Go to RESP.
  - If done and timeout coincide, done wins.
- RESP:
  - core_rst=1 so the core is parked. rsp_valid=1 with data/err/id stable until sampled with rsp_ready=1, then go to IDLE.
  - No new grant while in RESP or LOAD/RUN. req_ready stays 0.
- Operand registers keep their last values in IDLE.
- Minimum job latency from grant to rsp_valid = 1 + RST_CYCLES + run cycles.
- req_valid deasserting after grant has no effect. Requesters must hold operands stable only in the grant cycle.
- N_REQ=1 degenerates to a plain sequencer. The rr pointer stays at 0.

Decomposition:
- Shared package rv32_sched_pkg holds:
  - state enum {IDLE, LOAD, RUN, RESP}
  - err codes ERR_OK=2'b00, ERR_NOMMIO=2'b01, ERR_TIMEOUT=2'b10
  - op code constants matching the core's io_op encoding
- Sub-module rv32_rr_arbiter: combinational round-robin pick (req vector, pointer -> one-hot grant, index, any).

Test Plan:
- Single job: req0 a=21 b=9 op=0; core model asserts done 50 cycles after release with out_valid=1, res=30 -> core_rst high 4 cycles then low; rsp_id=0 rsp_data=30 rsp_err=00; rsp_valid 1+4+51 cycles after grant.
- Round-robin: all four req_valid held high, each core job 10 cycles -> grants in order 0,1,2,3,0; each req_ready a single one-cycle pulse; rsp_id sequence matches.
- Timeout (TIMEOUT=100): core never raises done -> rsp_err=10, rsp_data=0 after exactly 100 RUN cycles; core_rst=1 in RESP; next job proceeds normally.
- No MMIO write: done=1 with out_valid=0 -> rsp_err=01, rsp_data=0.
- Backpressure: rsp_ready low 10 cycles with req1 pending -> rsp fields stable, req_ready stays 0, busy=1; grant to req1 on the cycle after the handshake.
- Reset mid-RUN: rst_n low during RUN -> core_rst=1 and all outputs at reset values immediately; after release, the pending req2 is granted first.
